// File: rtl/mem_arb_if.sv
// Requester and memory-side bus of the two-port memory arbiter.
// The arbiter takes the slave view; requesters and the memory take the master view.
interface mem_arb_if #(
   parameter int unsigned AddrW = 12,
   parameter int unsigned DataW = 24
);
   logic             iw_a_req;
   logic [AddrW-1:0] iw_a_addr;
   logic             or_a_gnt;
   logic             or_a_rvalid;
   logic [DataW-1:0] or_a_rdata;

   logic             iw_b_req;
   logic             iw_b_we;
   logic [AddrW-1:0] iw_b_addr;
   logic [DataW-1:0] iw_b_wdata;
   logic             or_b_gnt;
   logic             or_b_rvalid;
   logic [DataW-1:0] or_b_rdata;

   logic             ow_mem_we;
   logic [AddrW-1:0] ow_mem_addr;
   logic [DataW-1:0] ow_mem_wdata;
   logic [DataW-1:0] iw_mem_rdata;

   modport master (
      output iw_a_req, iw_a_addr,
      input  or_a_gnt, or_a_rvalid, or_a_rdata,
      output iw_b_req, iw_b_we, iw_b_addr, iw_b_wdata,
      input  or_b_gnt, or_b_rvalid, or_b_rdata,
      input  ow_mem_we, ow_mem_addr, ow_mem_wdata,
      output iw_mem_rdata
   );

   modport slave (
      input  iw_a_req, iw_a_addr,
      output or_a_gnt, or_a_rvalid, or_a_rdata,
      input  iw_b_req, iw_b_we, iw_b_addr, iw_b_wdata,
      output or_b_gnt, or_b_rvalid, or_b_rdata,
      output ow_mem_we, ow_mem_addr, ow_mem_wdata,
      input  iw_mem_rdata
   );
endinterface

// File: rtl/mem_arb.sv
// Round-robin arbiter with starvation guard in front of a single-port synchronous memory.
// One access per cycle; read data is routed back with a one-cycle valid strobe.
module mem_arb #(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic     iw_clk,
   input logic     iw_rst,
   mem_arb_if.slave bus
);
   localparam logic [3:0] StarveLim = 4'(STARVE_MAX);

   logic       last_q, last_d;
   logic [3:0] starve_a_q, starve_a_d;
   logic [3:0] starve_b_q, starve_b_d;
   logic       rv_a_q, rv_a_d;
   logic       rv_b_q, rv_b_d;
   logic       pick_a, a_gnt, b_gnt;

   always_comb begin
      // On a tie, a starved port wins first (A if both), otherwise the port not served last.
      if (starve_a_q >= StarveLim)      pick_a = 1'b1;
      else if (starve_b_q >= StarveLim) pick_a = 1'b0;
      else                              pick_a = last_q;

      a_gnt = ~iw_rst & bus.iw_a_req & (~bus.iw_b_req | pick_a);
      b_gnt = ~iw_rst & bus.iw_b_req & (~bus.iw_a_req | ~pick_a);

      bus.ow_mem_we    = 1'b0;
      bus.ow_mem_addr  = '0;
      bus.ow_mem_wdata = '0;
      if (a_gnt) begin
         bus.ow_mem_addr = bus.iw_a_addr;
      end else if (b_gnt) begin
         bus.ow_mem_we    = bus.iw_b_we;
         bus.ow_mem_addr  = bus.iw_b_addr;
         bus.ow_mem_wdata = bus.iw_b_wdata;
      end

      last_d = last_q;
      if (a_gnt)      last_d = 1'b0;
      else if (b_gnt) last_d = 1'b1;

      starve_a_d = '0;
      if (bus.iw_a_req && !a_gnt) starve_a_d = (starve_a_q == 4'hf) ? 4'hf : starve_a_q + 4'h1;
      starve_b_d = '0;
      if (bus.iw_b_req && !b_gnt) starve_b_d = (starve_b_q == 4'hf) ? 4'hf : starve_b_q + 4'h1;

      rv_a_d = a_gnt;
      rv_b_d = b_gnt & ~bus.iw_b_we;
   end

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         last_q     <= 1'b0;
         starve_a_q <= '0;
         starve_b_q <= '0;
         rv_a_q     <= 1'b0;
         rv_b_q     <= 1'b0;
      end else begin
         last_q     <= last_d;
         starve_a_q <= starve_a_d;
         starve_b_q <= starve_b_d;
         rv_a_q     <= rv_a_d;
         rv_b_q     <= rv_b_d;
      end
   end

   // Reset gates the strobes so a response already pending when reset arrives is dropped.
   assign bus.or_a_gnt    = a_gnt;
   assign bus.or_b_gnt    = b_gnt;
   assign bus.or_a_rvalid = rv_a_q & ~iw_rst;
   assign bus.or_b_rvalid = rv_b_q & ~iw_rst;
   assign bus.or_a_rdata  = bus.or_a_rvalid ? bus.iw_mem_rdata : '0;
   assign bus.or_b_rdata  = bus.or_b_rvalid ? bus.iw_mem_rdata : '0;
endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural 4096x24 synchronous memory model.
module tb_mem_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_arb_if #(.AddrW(12), .DataW(24)) bus ();

   mem_arb #(.STARVE_MAX(4)) dut (
      .iw_clk (clk),
      .iw_rst (rst),
      .bus    (bus.slave)
   );

   always #5 clk = ~clk;

   // Registered read; a same-cycle write is seen by the following read only.
   logic [23:0] mem [4096];
   always @(posedge clk) begin
      if (bus.ow_mem_we) mem[bus.ow_mem_addr] <= bus.ow_mem_wdata;
      bus.iw_mem_rdata <= mem[bus.ow_mem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.iw_a_req   = 1'b0;
      bus.iw_a_addr  = '0;
      bus.iw_b_req   = 1'b0;
      bus.iw_b_we    = 1'b0;
      bus.iw_b_addr  = '0;
      bus.iw_b_wdata = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic exp_b, prev_a, prev_b;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[12'h005] = 24'h00abcd;
      bus.iw_mem_rdata = '0;
      idle_inputs();

      // Reset with both requests high: no grant, no memory write.
      bus.iw_a_req = 1'b1;
      bus.iw_b_req = 1'b1;
      bus.iw_b_we  = 1'b1;
      step();
      step();
      check_eq("rst_a_gnt", bus.or_a_gnt, 0);
      check_eq("rst_b_gnt", bus.or_b_gnt, 0);
      check_eq("rst_mem_we", bus.ow_mem_we, 0);
      check_eq("rst_a_rvalid", bus.or_a_rvalid, 0);
      check_eq("rst_b_rvalid", bus.or_b_rvalid, 0);
      check_eq("rst_a_rdata", bus.or_a_rdata, 0);
      check_eq("rst_b_rdata", bus.or_b_rdata, 0);
      idle_inputs();
      rst = 1'b0;
      #1;
      check_eq("idle_mem_addr", bus.ow_mem_addr, 0);

      // Single A read of 0x005.
      bus.iw_a_req  = 1'b1;
      bus.iw_a_addr = 12'h005;
      #1;
      check_eq("a_rd_gnt", bus.or_a_gnt, 1);
      check_eq("a_rd_addr", bus.ow_mem_addr, 12'h005);
      check_eq("a_rd_we", bus.ow_mem_we, 0);
      step();
      idle_inputs();
      #1;
      check_eq("a_rd_rvalid", bus.or_a_rvalid, 1);
      check_eq("a_rd_rdata", bus.or_a_rdata, 24'h00abcd);
      check_eq("a_rd_b_rvalid", bus.or_b_rvalid, 0);
      step();
      check_eq("a_rd_rvalid_once", bus.or_a_rvalid, 0);

      // B write 0x010 then B read 0x010 back to back.
      bus.iw_b_req   = 1'b1;
      bus.iw_b_we    = 1'b1;
      bus.iw_b_addr  = 12'h010;
      bus.iw_b_wdata = 24'h123456;
      #1;
      check_eq("b_wr_gnt", bus.or_b_gnt, 1);
      check_eq("b_wr_we", bus.ow_mem_we, 1);
      check_eq("b_wr_wdata", bus.ow_mem_wdata, 24'h123456);
      step();
      bus.iw_b_we = 1'b0;
      #1;
      check_eq("b_wr_no_rvalid", bus.or_b_rvalid, 0);
      check_eq("b_rd_gnt", bus.or_b_gnt, 1);
      check_eq("b_rd_we", bus.ow_mem_we, 0);
      step();
      idle_inputs();
      #1;
      check_eq("b_rd_rvalid", bus.or_b_rvalid, 1);
      check_eq("b_rd_rdata", bus.or_b_rdata, 24'h123456);
      step();

      // Both requesting for 8 cycles after reset: B, A, B, A, ...
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.iw_a_req  = 1'b1;
      bus.iw_a_addr = 12'h005;
      bus.iw_b_req  = 1'b1;
      bus.iw_b_addr = 12'h010;
      prev_a = 1'b0;
      prev_b = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_b = (i % 2 == 0);
         #1;
         check_eq($sformatf("rr_b_gnt%0d", i), bus.or_b_gnt, exp_b);
         check_eq($sformatf("rr_a_gnt%0d", i), bus.or_a_gnt, !exp_b);
         check_eq($sformatf("rr_a_rvalid%0d", i), bus.or_a_rvalid, prev_a);
         check_eq($sformatf("rr_b_rvalid%0d", i), bus.or_b_rvalid, prev_b);
         if (prev_a) check_eq($sformatf("rr_a_rdata%0d", i), bus.or_a_rdata, 24'h00abcd);
         if (prev_b) check_eq($sformatf("rr_b_rdata%0d", i), bus.or_b_rdata, 24'h123456);
         prev_a = !exp_b;
         prev_b = exp_b;
         step();
      end
      idle_inputs();
      #1;
      check_eq("rr_last_a_rvalid", bus.or_a_rvalid, prev_a);
      check_eq("rr_last_a_rdata", bus.or_a_rdata, 24'h00abcd);
      step();

      // Round-robin pinned to favour B: A must win on the 5th contested cycle.
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.iw_a_req = 1'b1;
      bus.iw_b_req = 1'b1;
      force dut.last_q = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check_eq($sformatf("starve_a_gnt%0d", i), bus.or_a_gnt, (i == 4));
         step();
      end
      release dut.last_q;
      #1;
      check_eq("starve_b_after", bus.or_b_gnt, 1);
      idle_inputs();
      step();

      // Reset the cycle after an A grant drops the pending response.
      bus.iw_a_req  = 1'b1;
      bus.iw_a_addr = 12'h005;
      #1;
      check_eq("rstmid_a_gnt", bus.or_a_gnt, 1);
      step();
      rst = 1'b1;
      bus.iw_b_req = 1'b1;
      bus.iw_b_we  = 1'b1;
      #1;
      check_eq("rstmid_a_rvalid", bus.or_a_rvalid, 0);
      check_eq("rstmid_a_rdata", bus.or_a_rdata, 0);
      check_eq("rstmid_a_gnt0", bus.or_a_gnt, 0);
      check_eq("rstmid_b_gnt0", bus.or_b_gnt, 0);
      check_eq("rstmid_mem_we", bus.ow_mem_we, 0);
      step();
      check_eq("rstmid_a_rvalid2", bus.or_a_rvalid, 0);
      check_eq("rstmid_mem_we2", bus.ow_mem_we, 0);
      rst = 1'b0;
      idle_inputs();
      step();
      check_eq("rstmid_post_rvalid", bus.or_a_rvalid, 0);

      // B writes 0xFFF alone, then A reads it back.
      bus.iw_b_req   = 1'b1;
      bus.iw_b_we    = 1'b1;
      bus.iw_b_addr  = 12'hfff;
      bus.iw_b_wdata = 24'ha5a5a5;
      #1;
      check_eq("top_b_gnt", bus.or_b_gnt, 1);
      check_eq("top_mem_we", bus.ow_mem_we, 1);
      check_eq("top_mem_addr", bus.ow_mem_addr, 12'hfff);
      step();
      idle_inputs();
      bus.iw_a_req  = 1'b1;
      bus.iw_a_addr = 12'hfff;
      #1;
      check_eq("top_we_pulse", bus.ow_mem_we, 0);
      check_eq("top_b_no_rvalid", bus.or_b_rvalid, 0);
      check_eq("top_a_gnt", bus.or_a_gnt, 1);
      step();
      idle_inputs();
      #1;
      check_eq("top_a_rvalid", bus.or_a_rvalid, 1);
      check_eq("top_a_rdata", bus.or_a_rdata, 24'ha5a5a5);
      check_eq("top_b_rvalid", bus.or_b_rvalid, 0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
